// File: rtl/upsampler_v_window_gen_fp16.sv
// +----------------------------------------------------------------------------+
// | upsampler_v_window_gen_fp16: 5x1 column windows of a 2x zero-inserted image |
// | Option: UPSAMPLER_V_WINDOW_EDGE_REPLICATE_EN (edge-row replication)        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module upsampler_v_window_gen_fp16 #(
  parameter int EXP_WIDTH    = 5,
  parameter int FRAC_WIDTH   = 10,
  parameter int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH,
  parameter int IMG_WIDTH    = 640,
  parameter int IMG_HEIGHT   = 480
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [FP_WIDTH_REG-1:0]               data_i,
  input  logic                                  valid_i,
  output logic                                  ready_o,
  output logic [4:0][0:0][FP_WIDTH_REG-1:0]     window_o,
  output logic [15:0]                           col_o,
  output logic [15:0]                           row_o,
  output logic                                  valid_o
);

  localparam int              c_aw       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [c_aw-1:0] c_last_col = c_aw'(IMG_WIDTH - 1);
  localparam logic [15:0]     c_last_row = 16'(IMG_HEIGHT - 1);
  localparam logic [15:0]     c_fe_row   = 16'(2 * IMG_HEIGHT - 2);
  localparam logic [15:0]     c_fo_row   = 16'(2 * IMG_HEIGHT - 1);

  localparam logic [2:0] c_fill    = 3'd0;
  localparam logic [2:0] c_even    = 3'd1;
  localparam logic [2:0] c_odd     = 3'd2;
  localparam logic [2:0] c_flush_e = 3'd3;
  localparam logic [2:0] c_flush_o = 3'd4;

  // Per-slot window source: zero, one of the three line buffers, or the bypassed pixel
  localparam logic [2:0] c_src_zero = 3'd0;
  localparam logic [2:0] c_src_byp  = 3'd4;

`ifdef UPSAMPLER_V_WINDOW_EDGE_REPLICATE_EN
  localparam bit c_edge_rep = 1'b1;
`else
  localparam bit c_edge_rep = 1'b0;
`endif

  function automatic logic [2:0] buf_src(input logic [1:0] b);
    return {1'b0, b} + 3'd1;
  endfunction

  logic [2:0]                    state_q, state_d;
  logic [c_aw-1:0]               in_col_q, in_col_d;
  logic [15:0]                   in_row_q, in_row_d;
  logic [1:0]                    buf_q, buf_d;
  logic                          valid_q, valid_d;
  logic [15:0]                   col_q, col_d;
  logic [15:0]                   row_q, row_d;
  logic [4:0][2:0]               src_q, src_d;
  logic [FP_WIDTH_REG-1:0]       byp_q, byp_d;

  logic                          w_ready, w_xfer, w_last_col, w_issue, w_we;
  logic [1:0]                    w_next, w_prev1, w_prev2;
  logic [2:0][FP_WIDTH_REG-1:0]  rd_data;

  assign w_next  = (buf_q == 2'd2) ? 2'd0 : buf_q + 2'd1;
  assign w_prev1 = (buf_q == 2'd0) ? 2'd2 : buf_q - 2'd1;
  assign w_prev2 = w_next;

  assign w_ready    = (state_q == c_fill) || (state_q == c_even);
  assign w_xfer     = valid_i && w_ready;
  assign w_last_col = (in_col_q == c_last_col);

  always_comb begin
    state_d  = state_q;
    in_col_d = in_col_q;
    in_row_d = in_row_q;
    buf_d    = buf_q;
    valid_d  = 1'b0;
    col_d    = col_q;
    row_d    = row_q;
    src_d    = src_q;
    byp_d    = byp_q;
    w_issue  = 1'b0;
    w_we     = 1'b0;
    case (state_q)
      c_fill: begin
        if (w_xfer) begin
          w_we     = 1'b1;
          in_col_d = w_last_col ? '0 : in_col_q + 1'b1;
          if (w_last_col) begin
            state_d  = c_even;
            in_row_d = in_row_q + 16'd1;
            buf_d    = w_next;
          end
        end
      end
      c_even: begin
        if (w_xfer) begin
          w_we     = 1'b1;
          w_issue  = 1'b1;
          row_d    = (in_row_q << 1) - 16'd2;
          // Top slot is R(j-2); for j==1 that is the frame's upper boundary
          src_d[0] = (in_row_q == 16'd1) ? (c_edge_rep ? buf_src(w_prev1) : c_src_zero)
                                         : buf_src(w_prev2);
          src_d[1] = c_src_zero;
          src_d[2] = buf_src(w_prev1);
          src_d[3] = c_src_zero;
          src_d[4] = c_src_byp;
          byp_d    = data_i;
          in_col_d = w_last_col ? '0 : in_col_q + 1'b1;
          if (w_last_col) state_d = c_odd;
        end
      end
      c_odd: begin
        w_issue  = 1'b1;
        row_d    = (in_row_q << 1) - 16'd1;
        src_d    = {c_src_zero, buf_src(buf_q), c_src_zero, buf_src(w_prev1), c_src_zero};
        in_col_d = w_last_col ? '0 : in_col_q + 1'b1;
        if (w_last_col) begin
          if (in_row_q < c_last_row) begin
            state_d  = c_even;
            in_row_d = in_row_q + 16'd1;
            buf_d    = w_next;
          end else begin
            state_d  = c_flush_e;
          end
        end
      end
      c_flush_e: begin
        w_issue  = 1'b1;
        row_d    = c_fe_row;
        src_d    = {(c_edge_rep ? buf_src(buf_q) : c_src_zero), c_src_zero,
                    buf_src(buf_q), c_src_zero, buf_src(w_prev1)};
        in_col_d = w_last_col ? '0 : in_col_q + 1'b1;
        if (w_last_col) state_d = c_flush_o;
      end
      c_flush_o: begin
        w_issue  = 1'b1;
        row_d    = c_fo_row;
        src_d    = {c_src_zero, (c_edge_rep ? buf_src(buf_q) : c_src_zero),
                    c_src_zero, buf_src(buf_q), c_src_zero};
        in_col_d = w_last_col ? '0 : in_col_q + 1'b1;
        if (w_last_col) begin
          state_d  = c_fill;
          in_row_d = '0;
          buf_d    = 2'd0;
        end
      end
      default: state_d = c_fill;
    endcase
    if (w_issue) begin
      valid_d = 1'b1;
      col_d   = 16'(in_col_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= c_fill;
      in_col_q <= '0;
      in_row_q <= '0;
      buf_q    <= 2'd0;
      valid_q  <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      src_q    <= '0;
      byp_q    <= '0;
    end else begin
      state_q  <= state_d;
      in_col_q <= in_col_d;
      in_row_q <= in_row_d;
      buf_q    <= buf_d;
      valid_q  <= valid_d;
      col_q    <= col_d;
      row_q    <= row_d;
      src_q    <= src_d;
      byp_q    <= byp_d;
    end
  end

  // Read registers only advance on an issued window, so the outputs hold between windows
  for (genvar b = 0; b < 3; b++) begin : g_lbuf
    logic [FP_WIDTH_REG-1:0] mem [IMG_WIDTH];
    logic [FP_WIDTH_REG-1:0] rd_q;
    always_ff @(posedge clk_i) begin
      if (w_we && (buf_q == 2'(b))) mem[in_col_q] <= data_i;
      if (w_issue) rd_q <= mem[in_col_q];
    end
    assign rd_data[b] = rd_q;
  end

  always_comb begin
    for (int s = 0; s < 5; s++) begin
      case (src_q[s])
        3'd1:      window_o[s][0] = rd_data[0];
        3'd2:      window_o[s][0] = rd_data[1];
        3'd3:      window_o[s][0] = rd_data[2];
        c_src_byp: window_o[s][0] = byp_q;
        default:   window_o[s][0] = '0;
      endcase
    end
  end

  assign ready_o = w_ready;
  assign valid_o = valid_q;
  assign col_o   = col_q;
  assign row_o   = row_q;

endmodule

`default_nettype wire

// File: tb/tb_upsampler_v_window_gen_fp16.sv
// Scoreboard bench for upsampler_v_window_gen_fp16 on a 4x3 frame.
`default_nettype none

module tb_upsampler_v_window_gen_fp16;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int FP = 16;

  logic                      clk = 1'b0;
  logic                      rst_i;
  logic [FP-1:0]             data_i;
  logic                      valid_i;
  logic                      ready_o;
  logic [4:0][0:0][FP-1:0]   window_o;
  logic [15:0]               col_o;
  logic [15:0]               row_o;
  logic                      valid_o;

  upsampler_v_window_gen_fp16 #(
    .EXP_WIDTH(5), .FRAC_WIDTH(10), .IMG_WIDTH(W), .IMG_HEIGHT(H)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .window_o(window_o), .col_o(col_o), .row_o(row_o),
    .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0][0:0][FP-1:0] win;
    logic [15:0]             col;
    logic [15:0]             row;
  } exp_t;

  exp_t          exp_q[$];
  bit            rdy_rec[$];
  int            checks = 0;
  int            errors = 0;
  bit            sb_en  = 1'b0;
  bit            rec_en = 1'b0;
  logic [FP-1:0] frame [H][W];

  // Zero-inserted image column value at output row y
  function automatic logic [FP-1:0] zval(input int y, input int c);
    int k;
    if ((y % 2) != 0) return '0;
    k = (y < 0) ? -1 : y / 2;
    if (k < 0 || k >= H) begin
`ifdef UPSAMPLER_V_WINDOW_EDGE_REPLICATE_EN
      k = (k < 0) ? 0 : H - 1;
`else
      return '0;
`endif
    end
    return frame[k][c];
  endfunction

  task automatic push_frame();
    exp_t e;
    for (int r = 0; r < 2 * H; r++)
      for (int c = 0; c < W; c++) begin
        for (int s = 0; s < 5; s++) e.win[s][0] = zval(r - 2 + s, c);
        e.col = 16'(c);
        e.row = 16'(r);
        exp_q.push_back(e);
      end
  endtask

  task automatic fill_random();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) frame[r][c] = 16'($urandom);
  endtask

  task automatic fill_pattern();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) frame[r][c] = 16'(16'h3C00 * (r + 1));
  endtask

  task automatic drive_frame(input bit gaps, input int npix);
    int idx = 0;
    int guard = 0;
    bit v, rdy;
    while (idx < npix) begin
      v       = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      valid_i = v;
      data_i  = frame[idx / W][idx % W];
      rdy     = ready_o;
      if (rec_en) rdy_rec.push_back(rdy);
      @(posedge clk); #1;
      if (v && rdy) idx++;
      guard++;
      if (guard > 2000) begin
        checks++; errors++;
        $display("FAIL drive_timeout accepted=%0d required=%0d", idx, npix);
        break;
      end
    end
    valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain outstanding=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || window_o !== '0 || col_o !== 16'd0 || row_o !== 16'd0) begin
      errors++;
      $display("FAIL %s got valid=%b ready=%b win=%h col=%0d row=%0d required valid=0 ready=1 win=0 col=0 row=0",
               name, valid_o, ready_o, window_o, col_o, row_o);
    end
  endtask

  always @(negedge clk) begin
    if (sb_en && valid_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_window got row=%0d col=%0d win=%h required none", row_o, col_o, window_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (window_o !== e.win || col_o !== e.col || row_o !== e.row) begin
          errors++;
          $display("FAIL window got row=%0d col=%0d win=%h required row=%0d col=%0d win=%h",
                   row_o, col_o, window_o, e.row, e.col, e.win);
        end
      end
    end
  end

  initial begin
    bit exp_rdy[$];
    int bad;
    rst_i   = 1'b1;
    valid_i = 1'b0;
    data_i  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset_state");
    rst_i = 1'b0;
    sb_en = 1'b1;

    // Two back-to-back frames with valid_i held high; record ready_o across them
    rec_en = 1'b1;
    fill_random(); push_frame(); drive_frame(1'b0, W * H);
    fill_random(); push_frame(); drive_frame(1'b0, W * H);
    rec_en = 1'b0;
    wait_drain();

    for (int i = 0; i < W; i++) exp_rdy.push_back(1'b1);
    for (int j = 1; j < H; j++) begin
      for (int i = 0; i < W; i++) exp_rdy.push_back(1'b1);
      for (int i = 0; i < W; i++) exp_rdy.push_back(1'b0);
    end
    for (int i = 0; i < 2 * W; i++) exp_rdy.push_back(1'b0);
    for (int i = 0; i < W; i++) exp_rdy.push_back(1'b1);
    bad = 0;
    for (int i = 0; i < exp_rdy.size(); i++)
      if (i >= rdy_rec.size() || rdy_rec[i] != exp_rdy[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ready_pattern got %0d mismatching cycles of %0d recorded required 0", bad, rdy_rec.size());
    end

    // Pattern frame with random input gaps
    fill_pattern(); push_frame(); drive_frame(1'b1, W * H);
    wait_drain();

    // Reset during the second input row, then a clean frame
    sb_en = 1'b0;
    fill_pattern();
    drive_frame(1'b0, W + 2);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    check_idle("midframe_reset");
    sb_en = 1'b1;
    fill_pattern(); push_frame(); drive_frame(1'b0, W * H);
    wait_drain();

    // Random data with gaps
    fill_random(); push_frame(); drive_frame(1'b1, W * H);
    fill_random(); push_frame(); drive_frame(1'b1, W * H);
    wait_drain();

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
